// File: rtl/ariane_pkg.sv
// Shared execute/writeback types used by the writeback merge buffer.
// Provides the scoreboard transaction ID width, the exception record and the
// buffered writeback entry {trans_id, result, exception}.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               exception;
  } wb_entry_t;

endpackage

// File: rtl/wb_merge_buffer_fifo.sv
// wb_src_fifo: circular buffer of writeback entries for one result producer.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   flush_i          clears count/pointers; push and pop ignored that cycle
//   push_i, data_i   enqueue request and entry (producer cannot be stalled)
//   pop_i            remove head (only honoured when non-empty)
//   head_o           entry at the read pointer (valid when count_o != 0)
//   count_o          occupancy, 0..DEPTH
//   afull_o          count_o >= DEPTH-1
//   drop_o           push lost because the buffer was full with no pop
module wb_src_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  wb_entry_t        data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             afull_o,
  output logic             drop_o
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_o == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_o != '0) && !flush_i;
  // A full buffer still accepts a push when its head leaves in the same cycle.
  assign do_push = push_i && !flush_i && (!full || do_pop);
  assign drop_o  = push_i && !flush_i && full && !do_pop;
  assign afull_o = (count_o >= CNT_W'(DEPTH - 1));
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count_o covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/wb_merge_buffer.sv
// wb_merge_buffer: buffers results from non-stallable writeback producers
// (0=FLU, 1=load, 2=store, 3=FPU) in per-source FIFOs and merges them
// round-robin onto NR_WB scoreboard writeback ports.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            synchronous flush of all buffered results
//   src_*              per-source valid pulse and {trans_id, result, exception}
//   src_afull_o        per-source FIFO holds >= FIFO_DEPTH-1 entries
//   wb_valid_o/ready_i per-port handshake; data is zero when a port is idle
//   wb_*_o             writeback {trans_id, result, exception}
//   overflow_o         sticky: a result was dropped (cleared only by reset)
module wb_merge_buffer #(
  parameter int unsigned NR_SRC        = 4,
  parameter int unsigned NR_WB         = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             flush_i,
  input  logic [NR_SRC-1:0]                                src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]             src_trans_id_i,
  input  logic [NR_SRC-1:0][63:0]                          src_result_i,
  input  logic [NR_SRC-1:0][$bits(ariane_pkg::exception_t)-1:0] src_exception_i,
  output logic [NR_SRC-1:0]                                src_afull_o,
  output logic [NR_WB-1:0]                                 wb_valid_o,
  input  logic [NR_WB-1:0]                                 wb_ready_i,
  output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]              wb_trans_id_o,
  output logic [NR_WB-1:0][63:0]                           wb_result_o,
  output logic [NR_WB-1:0][$bits(ariane_pkg::exception_t)-1:0] wb_exception_o,
  output logic                                             overflow_o
);

  localparam int unsigned PKG_ID_W = ariane_pkg::TRANS_ID_BITS;
  localparam int unsigned RR_W     = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

  ariane_pkg::wb_entry_t [NR_SRC-1:0] push_data;
  ariane_pkg::wb_entry_t [NR_SRC-1:0] head;
  logic [NR_SRC-1:0][CNT_W-1:0]       count;
  logic [NR_SRC-1:0]                  nonempty;
  logic [NR_SRC-1:0]                  pop;
  logic [NR_SRC-1:0]                  drop;
  logic [NR_SRC-1:0]                  ne_rot;
  logic [RR_W-1:0]                    rr_ptr;
  logic [RR_W-1:0]                    rr_next;
  logic [NR_WB-1:0]                   port_valid;
  logic [NR_WB-1:0][RR_W-1:0]         port_src;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    assign push_data[i] = {PKG_ID_W'(src_trans_id_i[i]), src_result_i[i], src_exception_i[i]};
    assign nonempty[i]  = (count[i] != '0);

    wb_src_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (src_valid_i[i]),
      .data_i  (push_data[i]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .count_o (count[i]),
      .afull_o (src_afull_o[i]),
      .drop_o  (drop[i])
    );
  end

  // Non-empty flags rotated so bit j is source (rr_ptr + j) mod NR_SRC.
  assign ne_rot = NR_SRC'({nonempty, nonempty} >> rr_ptr);

  // Allocation depends only on registered FIFO state and rr_ptr, never on
  // wb_ready_i, so valid cannot combinationally depend on ready.
  always_comb begin
    logic [RR_W:0] src_idx;
    int unsigned   found;
    port_valid = '0;
    port_src   = '0;
    found      = 0;
    for (int j = 0; j < NR_SRC; j++) begin
      src_idx = {1'b0, rr_ptr} + (RR_W + 1)'(j);
      if (src_idx >= (RR_W + 1)'(NR_SRC)) src_idx = src_idx - (RR_W + 1)'(NR_SRC);
      for (int k = 0; k < NR_WB; k++) begin
        if (ne_rot[j] && (found == k)) begin
          port_valid[k] = 1'b1;
          port_src[k]   = src_idx[RR_W-1:0];
        end
      end
      if (ne_rot[j]) found = found + 1;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      for (int k = 0; k < NR_WB; k++) begin
        if (port_valid[k] && wb_ready_i[k] && (port_src[k] == RR_W'(i))) pop[i] = 1'b1;
      end
    end
  end

  // Ports are filled in scan order, so the highest accepted port index is the
  // popped source latest in scan order.
  always_comb begin
    rr_next = rr_ptr;
    for (int k = 0; k < NR_WB; k++) begin
      if (port_valid[k] && wb_ready_i[k]) begin
        rr_next = (port_src[k] == RR_W'(NR_SRC - 1)) ? '0 : port_src[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (!flush_i) rr_ptr <= rr_next;
      if (|drop)    overflow_o <= 1'b1;
    end
  end

  always_comb begin
    ariane_pkg::wb_entry_t sel;
    wb_valid_o     = port_valid;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    for (int k = 0; k < NR_WB; k++) begin
      sel = '0;
      for (int i = 0; i < NR_SRC; i++) begin
        if (port_valid[k] && (port_src[k] == RR_W'(i))) sel = head[i];
      end
      wb_trans_id_o[k]  = TRANS_ID_BITS'(sel.trans_id);
      wb_result_o[k]    = sel.result;
      wb_exception_o[k] = sel.exception;
    end
  end

endmodule

// File: tb/tb_wb_merge_buffer.sv
module tb_wb_merge_buffer;
  import ariane_pkg::*;

  localparam int NR_SRC = 4;
  localparam int NR_WB  = 2;
  localparam int DEPTH  = 4;
  localparam int IDW    = TRANS_ID_BITS;
  localparam int EXC_W  = $bits(exception_t);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [NR_SRC-1:0]                src_valid;
  logic [NR_SRC-1:0][IDW-1:0]       src_trans_id;
  logic [NR_SRC-1:0][63:0]          src_result;
  logic [NR_SRC-1:0][EXC_W-1:0]     src_exception;
  logic [NR_SRC-1:0]                src_afull;
  logic [NR_WB-1:0]                 wb_valid;
  logic [NR_WB-1:0]                 wb_ready;
  logic [NR_WB-1:0][IDW-1:0]        wb_trans_id;
  logic [NR_WB-1:0][63:0]           wb_result;
  logic [NR_WB-1:0][EXC_W-1:0]      wb_exception;
  logic                             overflow;

  always #5 clk = ~clk;

  wb_merge_buffer #(
    .NR_SRC(NR_SRC), .NR_WB(NR_WB), .FIFO_DEPTH(DEPTH), .TRANS_ID_BITS(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_valid_i(src_valid), .src_trans_id_i(src_trans_id),
    .src_result_i(src_result), .src_exception_i(src_exception),
    .src_afull_o(src_afull),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_trans_id_o(wb_trans_id), .wb_result_o(wb_result),
    .wb_exception_o(wb_exception), .overflow_o(overflow)
  );

  // Scoreboard: one queue of expected entries per source, plus the expected
  // round-robin pointer and sticky overflow.
  wb_entry_t sb [NR_SRC][$];
  int   rr_m;
  logic ovf_exp;
  int   acc_cnt [NR_SRC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic model_clear();
    for (int i = 0; i < NR_SRC; i++) begin
      sb[i].delete();
      acc_cnt[i] = 0;
    end
    rr_m    = 0;
    ovf_exp = 1'b0;
  endtask

  task automatic drive_push(input int src, input int id, input int seq);
    exception_t ex;
    ex.cause  = 64'(seq * 7 + 1);
    ex.tval   = ~64'(seq);
    ex.valid  = seq[0];
    src_valid[src]     = 1'b1;
    src_trans_id[src]  = IDW'(id);
    src_result[src]    = {8'(src), 40'h0, 16'(seq)};
    src_exception[src] = ex;
  endtask

  // Checks the current outputs against the scoreboard, applies this cycle's
  // inputs to the scoreboard, then advances one clock (returns at negedge).
  task automatic tick();
    logic [NR_WB-1:0] ev;
    int es [NR_WB];
    int found;
    int s;
    int last;
    logic [NR_SRC-1:0] afull_exp;
    wb_entry_t got;
    wb_entry_t e;
    ev = '0;
    found = 0;
    for (int p = 0; p < NR_WB; p++) es[p] = 0;
    for (int j = 0; j < NR_SRC; j++) begin
      s = (rr_m + j) % NR_SRC;
      if (sb[s].size() > 0 && found < NR_WB) begin
        ev[found] = 1'b1;
        es[found] = s;
        found++;
      end
    end
    n_tests++;
    if (wb_valid !== ev) begin
      n_fail++;
      $display("FAIL alloc_valid: got %b, expected %b", wb_valid, ev);
    end
    for (int p = 0; p < NR_WB; p++) begin
      got = {wb_trans_id[p], wb_result[p], wb_exception[p]};
      n_tests++;
      if (ev[p]) begin
        if (got !== sb[es[p]][0]) begin
          n_fail++;
          $display("FAIL port%0d_data: got %h, expected %h (src %0d)", p, got, sb[es[p]][0], es[p]);
        end
      end else if (got !== '0) begin
        n_fail++;
        $display("FAIL port%0d_idle_zero: got %h, expected 0", p, got);
      end
    end
    for (int i = 0; i < NR_SRC; i++) afull_exp[i] = (sb[i].size() >= DEPTH - 1);
    n_tests++;
    if (src_afull !== afull_exp) begin
      n_fail++;
      $display("FAIL afull: got %b, expected %b", src_afull, afull_exp);
    end
    n_tests++;
    if (overflow !== ovf_exp) begin
      n_fail++;
      $display("FAIL overflow: got %b, expected %b", overflow, ovf_exp);
    end
    if (flush) begin
      for (int i = 0; i < NR_SRC; i++) sb[i].delete();
    end else begin
      last = -1;
      for (int p = 0; p < NR_WB; p++) begin
        if (ev[p] && wb_ready[p]) begin
          void'(sb[es[p]].pop_front());
          acc_cnt[es[p]]++;
          last = es[p];
        end
      end
      if (last >= 0) rr_m = (last + 1) % NR_SRC;
      for (int i = 0; i < NR_SRC; i++) begin
        if (src_valid[i]) begin
          e = {src_trans_id[i], src_result[i], src_exception[i]};
          if (sb[i].size() < DEPTH) sb[i].push_back(e);
          else ovf_exp = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    src_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    src_valid = '0;
    flush     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input int budget);
    int n;
    wb_ready = '1;
    n = 0;
    while (wb_valid !== '0 && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (wb_valid !== '0) begin
      n_fail++;
      $display("FAIL drain_timeout: wb_valid still %b after %0d cycles, expected 00", wb_valid, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = '1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (wb_valid !== '0 || src_afull !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b afull=%b ovf=%b, expected all 0", wb_valid, src_afull, overflow);
    end
    n_tests++;
    if (wb_trans_id !== '0 || wb_result !== '0 || wb_exception !== '0) begin
      n_fail++;
      $display("FAIL reset_data: id=%h res=%h, expected 0", wb_trans_id, wb_result);
    end
    src_valid = '0;
    rst = 1'b0;
    model_clear();
    wb_ready = '1;
    repeat (2) tick();
  endtask

  task automatic test_single_write();
    apply_reset();
    wb_ready = 2'b11;
    src_valid[0] = 1'b1;
    src_trans_id[0] = IDW'(3);
    src_result[0] = 64'hDEAD;
    src_exception[0] = '0;
    n_tests++;
    if (wb_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_no_bypass: wb_valid=%b, expected 00", wb_valid);
    end
    tick();
    n_tests++;
    if (wb_valid !== 2'b01 || wb_trans_id[0] !== IDW'(3) || wb_result[0] !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL single_port0: valid=%b id=%0d res=%h, expected 01 3 dead", wb_valid, wb_trans_id[0], wb_result[0]);
    end
    tick();
    n_tests++;
    if (wb_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_empty_after: wb_valid=%b, expected 00", wb_valid);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    wb_ready = 2'b11;
    for (int i = 0; i < NR_SRC; i++) drive_push(i, i, 16 + i);
    tick();
    n_tests++;
    if (wb_trans_id[0] !== IDW'(0) || wb_trans_id[1] !== IDW'(1)) begin
      n_fail++;
      $display("FAIL collision_first: ids %0d,%0d, expected 0,1", wb_trans_id[0], wb_trans_id[1]);
    end
    tick();
    n_tests++;
    if (wb_trans_id[0] !== IDW'(2) || wb_trans_id[1] !== IDW'(3) || wb_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL collision_second: valid=%b ids %0d,%0d, expected 11 2,3", wb_valid, wb_trans_id[0], wb_trans_id[1]);
    end
    tick();
    // rr_ptr should be back at 0: src1 must win port 0 over src3.
    drive_push(1, 5, 40);
    drive_push(3, 6, 41);
    tick();
    n_tests++;
    if (wb_trans_id[0] !== IDW'(5) || wb_trans_id[1] !== IDW'(6)) begin
      n_fail++;
      $display("FAIL collision_rr_wrap: ids %0d,%0d, expected 5,6", wb_trans_id[0], wb_trans_id[1]);
    end
    drain(8);
  endtask

  task automatic test_overflow();
    apply_reset();
    wb_ready = 2'b00;
    for (int n = 1; n <= 5; n++) begin
      drive_push(1, n, 100 + n);
      tick();
      n_tests++;
      if (src_afull[1] !== (n >= 3)) begin
        n_fail++;
        $display("FAIL ovf_afull_after_push%0d: got %b, expected %b", n, src_afull[1], (n >= 3));
      end
      n_tests++;
      if (overflow !== (n >= 5)) begin
        n_fail++;
        $display("FAIL ovf_flag_after_push%0d: got %b, expected %b", n, overflow, (n >= 5));
      end
    end
    drain(20);
    n_tests++;
    if (acc_cnt[1] !== 4) begin
      n_fail++;
      $display("FAIL ovf_drain_count: got %0d, expected 4", acc_cnt[1]);
    end
  endtask

  task automatic test_flush();
    wb_ready = 2'b00;
    drive_push(0, 1, 200);
    tick();
    drive_push(0, 2, 201);
    drive_push(3, 7, 202);
    tick();
    flush = 1'b1;
    wb_ready = 2'b11;
    drive_push(0, 6, 203);
    tick();
    n_tests++;
    if (wb_valid !== 2'b00 || src_afull !== '0) begin
      n_fail++;
      $display("FAIL flush_empty: valid=%b afull=%b, expected 00 0000", wb_valid, src_afull);
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_keeps_overflow: got %b, expected 1", overflow);
    end
    repeat (3) tick();
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    wb_ready = 2'b00;
    for (int n = 1; n <= 4; n++) begin
      drive_push(2, n, 300 + n);
      tick();
    end
    wb_ready = 2'b01;
    drive_push(2, 5, 305);
    tick();
    n_tests++;
    if (overflow !== 1'b0 || src_afull[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_state: ovf=%b afull=%b, expected 0 1", overflow, src_afull[2]);
    end
    wb_ready = 2'b00;
    drive_push(2, 6, 306);
    tick();
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_still_full: ovf=%b, expected 1", overflow);
    end
    drain(20);
    n_tests++;
    if (acc_cnt[2] !== 5) begin
      n_fail++;
      $display("FAIL fullpp_total: got %0d, expected 5", acc_cnt[2]);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    wb_ready = 2'b00;
    drive_push(0, 1, 400);
    drive_push(1, 2, 401);
    drive_push(2, 3, 402);
    tick();
    n_tests++;
    if (wb_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: valid=%b, expected 11", wb_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (wb_valid !== '0 || wb_trans_id !== '0 || wb_result !== '0 || wb_exception !== '0 || src_afull !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b id=%h res=%h afull=%b, expected all 0", wb_valid, wb_trans_id, wb_result, src_afull);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    wb_ready = 2'b11;
    repeat (3) tick();
    drive_push(3, 4, 403);
    tick();
    n_tests++;
    if (wb_valid !== 2'b01 || wb_trans_id[0] !== IDW'(4)) begin
      n_fail++;
      $display("FAIL midrst_new_push: valid=%b id=%0d, expected 01 4", wb_valid, wb_trans_id[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR_SRC; i++) begin
        if ($urandom_range(2) == 0) drive_push(i, int'($urandom_range(7)), 1000 + c * 4 + i);
      end
      wb_ready = NR_WB'($urandom_range(3));
      flush = ($urandom_range(49) == 0);
      tick();
    end
    drain(40);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    src_valid = '0;
    src_trans_id = '0;
    src_result = '0;
    src_exception = '0;
    wb_ready = '0;
    model_clear();
    test_reset();
    test_single_write();
    test_collision();
    test_overflow();
    test_flush();
    test_full_push_pop();
    test_reset_mid_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_merge_buffer.md
Name: wb_merge_buffer

Overview:
- Sits directly downstream of the execute stage, between its writeback producers and the scoreboard write ports.
- Producers are the fixed-latency unit, load, store and FPU. None of them accepts backpressure, so each gets a small per-source FIFO.
- Queued results are merged round-robin onto a smaller number of scoreboard writeback ports with a valid/ready handshake.
- Raises per-source almost-full flags so issue can stall before any result is lost.

Parameters:
- NR_SRC, 4, number of writeback sources (0=FLU, 1=load, 2=store, 3=FPU).
- NR_WB, 2, number of scoreboard writeback ports; 1 <= NR_WB <= NR_SRC.
- FIFO_DEPTH, 4, entries per source FIFO; power of two, >= 2.
- TRANS_ID_BITS, ariane_pkg::TRANS_ID_BITS, scoreboard transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- flush_i  in  1  synchronous flush of all buffered results.
- src_valid_i  in  NR_SRC  per-source result valid, single-cycle pulse, no ready.
- src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  per-source scoreboard ID.
- src_result_i  in  NR_SRC x 64  per-source result.
- src_exception_i  in  NR_SRC x $bits(exception_t)  per-source exception.
- src_afull_o  out  NR_SRC  FIFO holds >= FIFO_DEPTH-1 entries.
- wb_valid_o  out  NR_WB  writeback port valid.
- wb_ready_i  in  NR_WB  scoreboard accepts the port this cycle.
- wb_trans_id_o  out  NR_WB x TRANS_ID_BITS  writeback ID.
- wb_result_o  out  NR_WB x 64  writeback data.
- wb_exception_o  out  NR_WB x $bits(exception_t)  writeback exception.
- overflow_o  out  1  sticky: a result was dropped.

Behaviour:
- Reset (rst_i=1, any time):
  - All FIFOs empty and counts 0; rr_ptr=0.
  - overflow_o=0, src_afull_o=0, wb_valid_o=0.
  - All wb data outputs are 0.
  - Reset mid-operation discards all entries immediately.
- Enqueue: on the rising edge, if src_valid_i[i] && !flush_i, the {trans_id, result, exception} triple is written to FIFO i. Exception content passes through unmodified.
- Latency:
  - Fixed 1 cycle; no bypass.
  - A result enqueued at edge N is visible on a wb port no earlier than the cycle after edge N.
- Allocation (combinational from registered state only, never from wb_ready_i):
  - Scan sources rr_ptr, rr_ptr+1, ... mod NR_SRC.
  - The k-th non-empty source found drives wb port k, for k < NR_WB.
  - Unused ports have valid=0 and all data fields 0.
- Pop:
  - When wb_valid_o[k] && wb_ready_i[k], the head of the source mapped to port k is removed at the edge.
  - Ports are independent; partial acceptance is legal.
- Stability: valid and data on a port may change between cycles while ready is low. The scoreboard samples only on valid && ready.
- Round-robin: if at least one pop occurs, rr_ptr <= (highest-scan-order popped source + 1) mod NR_SRC. Otherwise rr_ptr holds.
- Count: count_i' = count_i + push - pop, range 0..FIFO_DEPTH. Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Full FIFO:
  - Push with a simultaneous pop of the same FIFO is legal; the count stays at FIFO_DEPTH.
  - Push without a pop drops the new entry, leaves the FIFO unchanged and sets overflow_o=1.
  - overflow_o clears only on reset; flush does not clear it.
- Empty FIFO with a push: the entry becomes visible next cycle; no same-cycle forwarding.
- src_afull_o[i]: registered-count compare, count_i >= FIFO_DEPTH-1.
- Flush:
  - All counts and pointers go to 0 at the edge.
  - Pushes and pops in the flush cycle are ignored. wb_valid_o is still driven in that cycle, but acceptance in the flush cycle has no effect on state.
  - rr_ptr is unchanged.

Decomposition:
- Shared package ariane_pkg provides exception_t, TRANS_ID_BITS, and a new typedef wb_entry_t = {trans_id, result, exception}.
- One sub-module: wb_src_fifo. It holds a parameterised-depth circular buffer of wb_entry_t with push, pop, flush, count and afull.
- The top instantiates NR_SRC copies of wb_src_fifo plus the rotating allocator and the rr_ptr register.

Test Plan:
- Single write: src0 pushes id=3, result=0xDEAD at edge N, wb_ready=11 → cycle N+1: port0 valid, id=3, result=0xDEAD; port1 valid=0 with data 0; FIFO0 empty after the edge.
- Four-way collision: all sources push ids 0..3 at edge N, ready=11, rr_ptr=0 → N+1: ports carry src0 and src1. N+2: src2 and src3, with rr_ptr=2 before that edge. Final rr_ptr=0.
- Backpressure and overflow: ready=00, src1 pushes 5 consecutive cycles with DEPTH=4 → afull[1] rises after the 3rd push; overflow_o=1 after the 5th. Draining yields exactly the first 4 IDs in order.
- Full push+pop: FIFO2 full, ready on its port=1, src2 pushes the same cycle → count stays 4, overflow_o stays 0, order preserved.
- Flush: 2 entries in FIFO0 and 1 in FIFO3, flush_i=1 with src0 pushing id=6 → next cycle all wb_valid=0, all counts 0, id=6 never appears.
- Reset mid-drain: rst_i asserted asynchronously with ports valid → outputs 0 immediately. After release, outputs stay idle until a new push.
